// File: rtl/krz_pkg.sv
// Shared krz SoC definitions: UART register word indices and STATUS bit layout.
// Mirrored in the firmware headers, so keep values in sync with them.
package krz_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_BAUD   = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LEVEL   = 8;
  localparam int STAT_LEVEL_W = 5;

endpackage

// File: rtl/krz_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers for full/empty detection.
// A pop and a push in the same cycle are both honoured even when full.
module krz_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/krz_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter: TX FIFO, per-frame baud divider, shift FSM.
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into S_START if more data queued
module krz_uart_tx
  import krz_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd103
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        tx,
  output logic        irq_tx_empty
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state, state_d;
  logic [7:0]  shift, shift_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [15:0] baud_cnt, baud_cnt_d;
  logic [15:0] div_lat, div_lat_d;
  logic        tx_q, tx_d;
  logic        ack_q, ovf, irq_q;
  logic [15:0] baud_div;
  logic        fifo_pop, fifo_full, fifo_empty, load_frame, tick;
  logic [7:0]  fifo_head;
  logic [LW-1:0] fifo_level;
  logic [1:0]  widx;
  logic        wr_txdata, wr_status, wr_baud;
  logic [31:0] status_w, rdata;
  logic        unused_bits;

  assign widx      = wb_adr_i[3:2];
  assign wr_txdata = ack_q & wb_we_i & (widx == UART_TXDATA);
  assign wr_status = ack_q & wb_we_i & (widx == UART_STATUS);
  assign wr_baud   = ack_q & wb_we_i & (widx == UART_BAUD);
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:16]};

  krz_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstz  (rstz),
    .push  (wr_txdata),
    .wdata (wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status_w = '0;
    status_w[STAT_FULL]  = fifo_full;
    status_w[STAT_EMPTY] = fifo_empty;
    status_w[STAT_BUSY]  = (state != S_IDLE);
    status_w[STAT_OVF]   = ovf;
    status_w[STAT_LEVEL +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    case (widx)
      UART_STATUS: rdata = status_w;
      UART_BAUD:   rdata = {16'd0, baud_div};
      default:     rdata = '0;
    endcase
  end

  assign wb_dat_o     = ack_q ? rdata : '0;
  assign wb_ack_o     = ack_q;
  assign tx           = tx_q;
  assign irq_tx_empty = irq_q;

  // A push into a full FIFO survives only if the FSM pops in the same cycle.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ack_q    <= 1'b0;
      ovf      <= 1'b0;
      baud_div <= BAUD_DIV_RST;
      irq_q    <= 1'b1;
    end else begin
      ack_q <= wb_stb_i & ~ack_q;
      if (wr_txdata && fifo_full && !fifo_pop) ovf <= 1'b1;
      else if (wr_status && wb_dat_i[STAT_OVF]) ovf <= 1'b0;
      if (wr_baud) baud_div <= wb_dat_i[15:0];
      irq_q <= (state == S_IDLE) & fifo_empty;
    end
  end

  assign tick = (baud_cnt == 16'd0);

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    baud_cnt_d = baud_cnt;
    div_lat_d  = div_lat;
    tx_d       = tx_q;
    load_frame = 1'b0;
    case (state)
      S_IDLE: begin
        tx_d       = 1'b1;
        load_frame = ~fifo_empty;
      end
      S_START: begin
        baud_cnt_d = baud_cnt - 16'd1;
        if (tick) begin
          baud_cnt_d = div_lat;
          bit_cnt_d  = 3'd0;
          tx_d       = shift[0];
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_cnt - 16'd1;
        if (tick) begin
          baud_cnt_d = div_lat;
          if (bit_cnt == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      S_STOP: begin
        baud_cnt_d = baud_cnt - 16'd1;
        if (tick) begin
          load_frame = ~fifo_empty;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Divider is latched here so a BAUD write never stretches a frame in flight.
    if (load_frame) begin
      shift_d    = fifo_head;
      div_lat_d  = baud_div;
      baud_cnt_d = baud_div;
      tx_d       = 1'b0;
      state_d    = S_START;
    end
  end

  assign fifo_pop = load_frame;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      div_lat  <= BAUD_DIV_RST;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      baud_cnt <= baud_cnt_d;
      div_lat  <= div_lat_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: doc/krz_uart_tx.md
Name: krz_uart_tx

Overview:
Memory-mapped 8N1 UART transmitter for the krz SoC; drives the top-level TX pin.
- Sits on the core's Wishbone data bus next to the GPIO block.
- Firmware pushes bytes into a small TX FIFO. A baud-rate generator and shift FSM serialise them LSB-first.
- Runs in the single SoC clock domain.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..16.
BAUD_DIV_RST, 16'd103, reset value of the baud divider; bit period = BAUD_DIV+1 clocks.

Ports:
clk  in  1  SoC clock
rstz  in  1  asynchronous active-low reset
wb_adr_i  in  4  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, valid while wb_ack_o=1
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe (cyc folded in)
wb_ack_o  out  1  single-cycle acknowledge
tx  out  1  serial output, idle high
irq_tx_empty  out  1  level interrupt: FIFO empty and FSM idle

Behaviour:
Reset (rstz=0, async):
- tx=1, wb_ack_o=0, wb_dat_o=0, irq_tx_empty=1.
- FIFO empty, FSM=IDLE, BAUD_DIV=BAUD_DIV_RST, overflow=0.

Bus:
- wb_ack_o = registered (wb_stb_i & ~wb_ack_o). Ack arrives 1 cycle after stb and is never high 2 consecutive cycles.
- The register action executes in the ack cycle.

Register map (word index = adr[3:2]):
- 0 TXDATA, write: push wdat[7:0]. If FIFO full, drop the byte and set overflow. Reads return 0.
- 1 STATUS, read: [0] full, [1] empty, [2] busy (FSM!=IDLE), [3] overflow, [8+:5] fill level.
  - Write with wdat[3]=1 clears overflow.
- 2 BAUD, R/W [15:0]. A new value is sampled at the START of each frame. An in-flight frame keeps its old divider.
- 3: reads 0, writes ignored; still acked.

Baud counter:
- 16-bit down-counter, loaded with the latched divider at each bit boundary.
- Bit-boundary tick when the count reaches 0.
- BAUD=0 gives 1 clock per bit (legal).

FSM (IDLE, START, DATA, STOP):
- IDLE: if FIFO not empty, pop the head into an 8-bit shift reg, latch the divider, go to START. The transition occurs 1 cycle after the FIFO becomes non-empty.
- START: tx=0 for one bit period, then DATA.
- DATA: tx=shift[0]; shift right on each tick; 3-bit bit counter; after bit 7, go to STOP.
- STOP: tx=1 for one bit period.
  - Then go directly to START if the FIFO is non-empty (pop in the same cycle, no idle gap); otherwise go to IDLE.
- Frame length = 10*(BAUD+1) clocks exactly.
- tx is driven from a flop (glitch-free).

FIFO:
- Circular buffer with rd/wr pointers of log2(FIFO_DEPTH)+1 bits; wrap-around via the MSB compare.
- Simultaneous push and pop when full: pop first, so the push is accepted with no overflow. Level is unchanged.
- Simultaneous push and pop when empty: not possible (pop requires non-empty).

Other rules:
- irq_tx_empty is registered; it asserts the cycle after the FSM returns to IDLE with the FIFO empty.
- Reset mid-frame: tx goes to 1 immediately (async) and the FIFO contents are lost.

Decomposition:
- krz_pkg: register index localparams (UART_TXDATA=0, UART_STATUS=1, UART_BAUD=2) and STATUS bit positions, shared with firmware headers.
- FSM state enum: local to the module.
- One sub-module: krz_sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/level). Reusable for a later RX path.

Test Plan:
1. BAUD=3, write TXDATA=0x55 -> tx low 4 clks at frame start, then bits 1,0,1,0,1,0,1,0 low-first alternating at 4 clks each, then high 4 clks. Total 40 clks; irq_tx_empty rises after.
2. BAUD=0, write 0xA5 then 0x3C back-to-back -> 20 contiguous bit-clocks with no idle between frames. Decoded bytes are 0xA5, 0x3C.
3. FIFO_DEPTH=4, BAUD=100, write 6 bytes fast:
   - 1 is popped into the FSM and 4 are queued, so STATUS.full=1 and level=4.
   - The 6th is dropped and STATUS.overflow=1.
   - Writing STATUS with 0x8 clears overflow. Exactly 5 bytes appear on tx.
4. Mid-frame write of BAUD 3->7 during byte 0x0F -> that frame keeps 4 clk/bit; the next queued frame uses 8 clk/bit.
5. Assert rstz=0 during DATA bit 4 -> tx=1 and wb_ack_o=0 within the same cycle. After release: STATUS reads 0x2 (empty) and BAUD reads BAUD_DIV_RST.
6. Hold wb_stb_i high for 4 cycles on a TXDATA write -> ack pattern 0,1,0,1. Two pushes occur, level=2 (BAUD large).
